// File: rtl/stack_register_if.sv
// Command and status bundle for stack_register; the shared tri-state bus stays a plain inout.
// The peek enable exists only when STACK_REGISTER_PEEK_EN is defined.
interface stack_register_if #(
    parameter int WIDTH = 16
);
    logic             load;
    logic             en;
    logic             inc;
    logic             dec;
    logic             push;
    logic             pop;
    logic             clr_err;
`ifdef STACK_REGISTER_PEEK_EN
    logic             en_top;
`endif
    logic [WIDTH-1:0] value;
    logic             carry;
    logic             zero;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    modport master (
`ifdef STACK_REGISTER_PEEK_EN
        output en_top,
`endif
        output load, en, inc, dec, push, pop, clr_err,
        input  value, carry, zero, full, empty, overflow, underflow
    );

    modport slave (
`ifdef STACK_REGISTER_PEEK_EN
        input  en_top,
`endif
        input  load, en, inc, dec, push, pop, clr_err,
        output value, carry, zero, full, empty, overflow, underflow
    );
endinterface

// File: rtl/stack_register.sv
// Bus register with up/down counter, push/pop save stack and carry/zero/error flags.
// State updates one clk edge after a command; bus drive is combinational. Optional macro: STACK_REGISTER_PEEK_EN.
module stack_register #(
    parameter int               WIDTH       = 16,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                clk,
    input  logic                reset_bar,
    inout  wire  [WIDTH-1:0]    bus,
    stack_register_if.slave     rif
);
    localparam int SW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] val_q;
    logic             carry_q;
    logic             ovf_q;
    logic             unf_q;
    logic [SW-1:0]    sp;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             is_empty;
    logic             is_full;
    logic             do_push;
    logic             do_pop;
    logic             push_err;
    logic             pop_err;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    top_idx;
    logic             drv_en;
    logic [WIDTH-1:0] drv_dat;

    assign is_empty = (sp == '0);
    assign is_full  = (sp == SW'(DEPTH));
    assign wr_idx   = IW'(sp);
    assign top_idx  = IW'(sp - SW'(1));

    // push+pop together cancel both stack operations and raise no error
    assign do_push  = rif.push & ~rif.pop & ~is_full;
    assign push_err = rif.push & ~rif.pop & is_full;
    assign pop_err  = rif.pop & ~rif.push & is_empty;
    // a load takes the register, so the pop must not move the stack pointer either
    assign do_pop   = rif.pop & ~rif.push & ~rif.load & ~is_empty;

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            val_q   <= RESET_VALUE;
            carry_q <= 1'b0;
            sp      <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (rif.load) begin
                val_q   <= bus;
                carry_q <= 1'b0;
            end else if (do_pop) begin
                val_q   <= mem[top_idx];
                carry_q <= 1'b0;
            end else if (rif.inc ^ rif.dec) begin
                if (rif.inc) begin
                    val_q   <= val_q + WIDTH'(1);
                    carry_q <= &val_q;
                end else begin
                    val_q   <= val_q - WIDTH'(1);
                    carry_q <= ~|val_q;
                end
            end

            if (do_push) begin
                sp <= sp + SW'(1);
            end else if (do_pop) begin
                sp <= sp - SW'(1);
            end

            // a fresh error outranks clr_err in the same cycle
            if (push_err) begin
                ovf_q <= 1'b1;
            end else if (rif.clr_err) begin
                ovf_q <= 1'b0;
            end
            if (pop_err) begin
                unf_q <= 1'b1;
            end else if (rif.clr_err) begin
                unf_q <= 1'b0;
            end
        end
    end

    // stack RAM carries no reset
    always_ff @(posedge clk) begin
        if (reset_bar && do_push) begin
            mem[wr_idx] <= val_q;
        end
    end

`ifdef STACK_REGISTER_PEEK_EN
    assign drv_en  = rif.en | rif.en_top;
    assign drv_dat = rif.en ? val_q : (is_empty ? '0 : mem[top_idx]);
`else
    assign drv_en  = rif.en;
    assign drv_dat = val_q;
`endif

    assign bus = drv_en ? drv_dat : {WIDTH{1'bz}};

    assign rif.value     = val_q;
    assign rif.carry     = carry_q;
    assign rif.zero      = (val_q == '0);
    assign rif.full      = is_full;
    assign rif.empty     = is_empty;
    assign rif.overflow  = ovf_q;
    assign rif.underflow = unf_q;
endmodule

// File: doc/stack_register.md
Name: stack_register

Overview:
- Parametrised successor to the plain bus register used for X/Y/IR.
- Adds an up/down counter, a push/pop save stack of configurable depth, and carry/zero/error flags.
- Sits on the shared tri-state CPU bus. Intended for PC and SP-style registers and for subroutine return-address save.
- Same bus contract as the plain register: loads from the bus on a rising clock edge, drives the bus only while enabled.

Parameters:
WIDTH, 16, data width of the register, bus and stack entries (>=2)
DEPTH, 4, number of stack entries (>=1)
RESET_VALUE, 0, value loaded into the register on reset

Ports:
clk  input  1  system clock; all state changes on rising edge
reset_bar  input  1  asynchronous active-low reset
bus  inout  WIDTH  shared tri-state CPU bus
load  input  1  capture bus into register at clock edge
en  input  1  drive register value onto bus
inc  input  1  increment register
dec  input  1  decrement register
push  input  1  save register value onto stack
pop  input  1  restore register from top of stack
clr_err  input  1  clear sticky overflow/underflow flags
value  output  WIDTH  current register value, always driven
carry  output  1  registered wrap flag from last inc/dec
zero  output  1  combinational, 1 when value == 0
full  output  1  stack holds DEPTH entries
empty  output  1  stack holds 0 entries
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Interface (already decided): one clock, clk. Reset is reset_bar, asynchronous and active-low.
- Reset, asserted asynchronously:
  - value=RESET_VALUE, stack pointer sp=0, empty=1, full=0.
  - carry=0, overflow=0, underflow=0.
  - Stack RAM contents are not reset.
- Bus output:
  - bus = value while en=1, else high-Z.
  - Combinational; no clock latency.
- Register update priority per rising edge (first match wins):
  1. load: value <= bus; carry <= 0.
  2. pop with sp>0: value <= stack[sp-1]; sp <= sp-1; carry <= 0.
  3. inc xor dec: value <= value±1 modulo 2^WIDTH.
     - carry <= 1 on wrap (inc from all-ones, dec from 0), else 0.
  4. Otherwise: value and carry hold.
- inc and dec both high: no arithmetic; carry holds.
- Push:
  - push with sp<DEPTH and pop=0: stack[sp] <= pre-edge value; sp <= sp+1.
  - Independent of load/inc/dec in the same cycle. Example: push+inc saves the old value and increments the register.
- push and pop both high: no stack operation. The register follows the remaining priority (load, then inc/dec).
- Errors:
  - push while full: ignored; overflow <= 1.
  - pop while empty: ignored; underflow <= 1; the register then follows the remaining priority.
- Sticky flags:
  - Cleared only by clr_err=1 at an edge, or by reset.
  - clr_err has lower priority than a new error in the same cycle: the flag stays 1.
- Flag outputs:
  - full = (sp==DEPTH).
  - empty = (sp==0).
  - zero is derived from value combinationally.
- Latency: value, sp and flags are valid one edge after the command. Popped data appears on value after that edge.
- Reset mid-operation: reset wins immediately; any in-flight push/pop is discarded.

Optional Feature:
- Macro: STACK_REGISTER_PEEK_EN.
- Defined:
  - Adds input port en_top (1 bit).
  - en_top=1 and en=0: bus = stack[sp-1], or all-zeros when empty.
  - en and en_top both 1: en wins, bus = value.
  - No state change.
- Undefined: port en_top is absent; the bus is driven only by en.

Test Plan:
- Reset: reset_bar=0 mid-cycle with value=0x1234 -> value=0x0000, empty=1, full=0, carry=0, overflow=0 immediately; bus high-Z with en=0.
- Load/drive: bus=0xBEEF, load=1, edge; then en=1 -> value=0xBEEF, bus=0xBEEF; en=0 -> bus high-Z.
- Counter wrap: value=0xFFFF, inc edge -> value=0x0000, carry=1, zero=1; then dec edge -> value=0xFFFF, carry=1; inc+dec edge -> value unchanged.
- Stack fill/drain (DEPTH=4): load 0x0010, then push+inc four times -> full=1, value=0x0014; fifth push -> overflow=1, sp unchanged; four pops -> value 0x0013, 0x0012, 0x0011, 0x0010, empty=1.
- Errors: pop while empty -> underflow=1, value unchanged; clr_err -> underflow=0; pop+clr_err while empty -> underflow stays 1.
- Priority: load=1, pop=1, sp=2, bus=0x00AA -> value=0x00AA, sp=2; push+pop with value=5, sp=1 -> sp=1, no stack change. With STACK_REGISTER_PEEK_EN: en_top=1, top=0x0011 -> bus=0x0011.
